// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Mealy digit-sequence detector
//
// Purpose: watches a stream of DIGIT_W-bit digits and pulses
// sequence_detected in the same cycle as the last digit of a programmed
// SEQ_LEN-digit pattern. The pattern can be rewritten while idle.
// Overlapping or non-overlapping detection is selectable, and a saturating
// counter records the matches seen since the last start.
//
// Optional macro: SEQ_DETECT_MASK_EN adds pat_mask_we and a per-position
// wildcard mask.
//
// Ports:
//   clk               rising-edge clock
//   asyn_n_rst        asynchronous active-low reset
//   start             enter/restart RUN; clears history, fill and count
//   stop              return to IDLE (wins over start)
//   overlap           1 = overlapping matches allowed
//   digit_valid       digit_in valid this cycle
//   digit_in          incoming digit
//   pat_we            pattern write strobe (IDLE only)
//   pat_addr          pattern digit index
//   pat_data          pattern digit value
//   pat_mask_we       (mask build only) redirect write to wildcard mask bit
//   sequence_detected combinational match pulse
//   match_count       saturating match count since start
//   busy              registered, 1 while in RUN
`timescale 1ns/1ps

module seq_detector_param #(
  parameter int DIGIT_W = 4,
  parameter int SEQ_LEN = 8,
  parameter logic [SEQ_LEN*DIGIT_W-1:0] DEFAULT_PATTERN = 32'h8244_4300,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       asyn_n_rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       overlap,
  input  logic                       digit_valid,
  input  logic [DIGIT_W-1:0]         digit_in,
  input  logic                       pat_we,
  input  logic [$clog2(SEQ_LEN)-1:0] pat_addr,
  input  logic [DIGIT_W-1:0]         pat_data,
`ifdef SEQ_DETECT_MASK_EN
  input  logic                       pat_mask_we,
`endif
  output logic                       sequence_detected,
  output logic [CNT_W-1:0]           match_count,
  output logic                       busy
);

  localparam int HW = (SEQ_LEN-1)*DIGIT_W;
  localparam int FW = $clog2(SEQ_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(SEQ_LEN-1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state;
  logic [HW-1:0]               hist;     // newest digit in the low bits
  logic [FW-1:0]               fill;
  logic [SEQ_LEN*DIGIT_W-1:0]  pattern;
  logic [SEQ_LEN-1:0]          mask;

  logic                        accept;
  logic                        hist_ok;
  logic                        last_ok;
  logic                        match;
  logic                        addr_ok;
  logic [HW+DIGIT_W-1:0]       shifted;

`ifndef SEQ_DETECT_MASK_EN
  assign mask = '0;
`endif

  assign accept  = (state == RUN) && digit_valid && !start && !stop;
  assign addr_ok = (32'(pat_addr) < SEQ_LEN);
  assign shifted = {hist, digit_in};

  // History oldest digit sits at the top, so history position i lines up
  // with pattern digit i.
  always_comb begin
    hist_ok = 1'b1;
    for (int i = 0; i < SEQ_LEN-1; i++) begin
      if (!mask[i] &&
          hist[(SEQ_LEN-2-i)*DIGIT_W +: DIGIT_W] != pattern[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W])
        hist_ok = 1'b0;
    end
    last_ok = mask[SEQ_LEN-1] || (digit_in == pattern[DIGIT_W-1:0]);
    match   = accept && (fill == FILL_MAX) && hist_ok && last_ok;
  end

  assign sequence_detected = match;

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      pattern     <= DEFAULT_PATTERN;
`ifdef SEQ_DETECT_MASK_EN
      mask        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state       <= RUN;
            busy        <= 1'b1;
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
          end else if (pat_we && addr_ok) begin
`ifdef SEQ_DETECT_MASK_EN
            if (pat_mask_we)
              mask[pat_addr] <= pat_data[0];
            else
              pattern[(SEQ_LEN-1-int'(pat_addr))*DIGIT_W +: DIGIT_W] <= pat_data;
`else
            pattern[(SEQ_LEN-1-int'(pat_addr))*DIGIT_W +: DIGIT_W] <= pat_data;
`endif
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (start) begin
            hist        <= '0;
            fill        <= '0;
            match_count <= '0;
          end else if (accept) begin
            hist <= shifted[HW-1:0];
            // Non-overlapping mode needs a full fresh sequence after a hit.
            if (match && !overlap)
              fill <= '0;
            else if (fill != FILL_MAX)
              fill <= fill + 1'b1;
            if (match && match_count != {CNT_W{1'b1}})
              match_count <= match_count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
